// File: rtl/stream_pkg.sv
// ---------------------------------------------------------------------------
// stream_pkg
// Shared definitions for the stream repacker:
//   - default beat widths and the matching count-field widths
//   - cnt_to_bytes(): decodes a count field where 0 means a full beat
// ---------------------------------------------------------------------------
package stream_pkg;

  localparam int IN_BYTES_DEF  = 8;
  localparam int OUT_BYTES_DEF = 8;
  localparam int IN_CNT_W      = $clog2(IN_BYTES_DEF);
  localparam int OUT_CNT_W     = $clog2(OUT_BYTES_DEF);

  // A count field is one bit too narrow to hold the full width, so the
  // full-beat case is carried as 0.
  function automatic int unsigned cnt_to_bytes(input int unsigned cnt,
                                               input int unsigned width);
    return (cnt == 0) ? width : cnt;
  endfunction

endpackage

// File: rtl/stream_byte_placer.sv
// ---------------------------------------------------------------------------
// stream_byte_placer
// Combinational helper: positions an input beat inside the repacker's byte
// buffer and produces the byte write mask for that buffer.
// Ports:
//   in_data_i  input beat, byte 0 in [7:0]
//   offset_i   buffer byte position that receives input byte 0
//   nbytes_i   number of input bytes to write (1..IN_BYTES)
//   data_o     input beat shifted up by offset_i bytes, buffer wide
//   mask_o     one bit per buffer byte, set where a new byte lands
// ---------------------------------------------------------------------------
module stream_byte_placer #(
  parameter int IN_BYTES  = 8,
  parameter int BUF_BYTES = 16,
  parameter int LW        = $clog2(BUF_BYTES + 1)
) (
  input  logic [8*IN_BYTES-1:0]  in_data_i,
  input  logic [LW-1:0]          offset_i,
  input  logic [LW-1:0]          nbytes_i,
  output logic [8*BUF_BYTES-1:0] data_o,
  output logic [BUF_BYTES-1:0]   mask_o
);

  logic [8*BUF_BYTES-1:0] in_ext;
  logic [LW:0]            end_pos;

  assign in_ext  = {{(8*(BUF_BYTES-IN_BYTES)){1'b0}}, in_data_i};
  assign data_o  = in_ext << {offset_i, 3'b000};
  // One extra bit so offset + count never wraps.
  assign end_pos = {1'b0, offset_i} + {1'b0, nbytes_i};

  genvar gi;
  generate
    for (gi = 0; gi < BUF_BYTES; gi++) begin : g_mask
      assign mask_o[gi] = ({1'b0, offset_i} <= (LW+1)'(gi)) &&
                          ((LW+1)'(gi) < end_pos);
    end
  endgenerate

endmodule

// File: rtl/stream_repacker.sv
// ---------------------------------------------------------------------------
// stream_repacker
// Repacks a byte stream of IN_BYTES-wide beats (only the final beat of a
// packet may be partial) into densely packed OUT_BYTES-wide beats.
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   in_data     input beat, byte 0 = [7:0] = first byte
//   in_cnt      valid input bytes from byte 0, 0 = full beat
//   in_last     final input beat of a packet
//   in_valid    input handshake from producer
//   in_ready    input accept; driven from registered state only
//   out_data    output beat, byte 0 oldest
//   out_cnt     valid output bytes, 0 = full beat
//   out_last    final output beat of a packet
//   out_valid   output handshake to consumer
//   out_ready   consumer accept
// ---------------------------------------------------------------------------
module stream_repacker
  import stream_pkg::*;
#(
  parameter int IN_BYTES  = IN_BYTES_DEF,
  parameter int OUT_BYTES = OUT_BYTES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8*IN_BYTES-1:0]         in_data,
  input  logic [$clog2(IN_BYTES)-1:0]   in_cnt,
  input  logic                          in_last,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [8*OUT_BYTES-1:0]        out_data,
  output logic [$clog2(OUT_BYTES)-1:0]  out_cnt,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int BUF_BYTES = IN_BYTES + OUT_BYTES;
  localparam int LW        = $clog2(BUF_BYTES + 1);
  localparam int OCW       = $clog2(OUT_BYTES);
  localparam logic [LW-1:0] OUT_LVL = LW'(OUT_BYTES);

  logic [8*BUF_BYTES-1:0] data_q, data_d;
  logic [LW-1:0]          lvl_q, lvl_d;
  logic                   pend_q, pend_d;

  logic [LW-1:0]          in_n, out_n, drop, base;
  logic                   in_fire, out_fire;
  logic [8*BUF_BYTES-1:0] shifted, placed;
  logic [BUF_BYTES-1:0]   wr_mask;

  assign in_n  = LW'(cnt_to_bytes(32'(in_cnt), IN_BYTES));
  assign out_n = (lvl_q >= OUT_LVL) ? OUT_LVL : lvl_q;

  // Input is only opened when the worst-case beat still fits after the
  // buffer holds at most one output beat; out_ready is deliberately absent.
  assign in_ready  = !pend_q && (lvl_q <= OUT_LVL);
  assign out_valid = (lvl_q >= OUT_LVL) || (pend_q && (lvl_q != '0));
  assign out_last  = pend_q && (lvl_q <= OUT_LVL);
  assign out_data  = data_q[8*OUT_BYTES-1:0];
  assign out_cnt   = out_n[OCW-1:0];

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Bytes leaving this edge are removed first; new bytes land right above
  // whatever remains, so shift and write share one edge.
  assign drop    = out_fire ? out_n : '0;
  assign base    = lvl_q - drop;
  assign shifted = data_q >> {drop, 3'b000};

  stream_byte_placer #(
    .IN_BYTES  (IN_BYTES),
    .BUF_BYTES (BUF_BYTES),
    .LW        (LW)
  ) u_placer (
    .in_data_i (in_data),
    .offset_i  (base),
    .nbytes_i  (in_n),
    .data_o    (placed),
    .mask_o    (wr_mask)
  );

  genvar gi;
  generate
    for (gi = 0; gi < BUF_BYTES; gi++) begin : g_byte
      assign data_d[8*gi +: 8] = (in_fire && wr_mask[gi]) ? placed[8*gi +: 8]
                                                          : shifted[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    lvl_d  = lvl_q;
    pend_d = pend_q;
    if (out_fire && out_last) begin
      // Input is blocked while a last is pending, so nothing can arrive here.
      lvl_d  = '0;
      pend_d = 1'b0;
    end else begin
      lvl_d = base + (in_fire ? in_n : '0);
      if (in_fire && in_last) begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      pend_q <= pend_d;
    end
    // Buffer contents are only meaningful below lvl, so they need no reset.
    data_q <= data_d;
  end

endmodule
